// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads IF/ID.
// Optional macro IF_PERF_CNT_EN adds fetch_count/flush_count performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_sel,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count,
`endif
  output logic [1:0]  dbg_state
);

  // Memory handshake: imem_req/imem_addr stay fixed from issue until the cycle
  // imem_valid=1 (possibly the issue cycle itself); a request is never withdrawn.
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2, S_DROP = 2'd3} state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic [31:0] r_drop_addr, w_drop_nx;
  logic [31:0] r_skid_pc, r_skid_instr;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic [31:0] r_if_pc, r_if_pc4, r_if_instr;
  logic        r_if_valid;
  logic        w_redirect;
  logic [31:0] w_target_raw, w_target;
  logic        w_load, w_bubble, w_skid_we;
  logic [31:0] w_load_pc, w_load_instr;

  assign w_redirect   = jump | branch_sel;
  assign w_target_raw = jump ? jump_target : branch_target;
  assign w_target     = w_target_raw & 32'hFFFF_FFFC;

  always_comb begin
    w_state_nx   = r_state;
    w_pc_nx      = r_pc;
    w_drop_nx    = r_drop_addr;
    w_load       = 1'b0;
    w_load_pc    = r_pc;
    w_load_instr = imem_rdata;
    w_bubble     = 1'b0;
    w_skid_we    = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nx = S_REQ;
        if (w_redirect) w_pc_nx = w_target;
      end
      S_REQ: begin
        if (w_redirect) begin
          w_pc_nx = w_target;
          // The outstanding request cannot be cancelled, so remember its address.
          if (!imem_valid) begin
            w_state_nx = S_DROP;
            w_drop_nx  = r_pc;
          end
        end else if (imem_valid) begin
          if (stall) begin
            w_skid_we  = 1'b1;
            w_state_nx = S_HOLD;
          end else begin
            w_load  = 1'b1;
            w_pc_nx = r_pc + 32'd4;
          end
        end else if (!stall) begin
          w_bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_pc_nx    = w_target;
          w_state_nx = S_REQ;
        end else if (!stall) begin
          w_load       = 1'b1;
          w_load_pc    = r_skid_pc;
          w_load_instr = r_skid_instr;
          w_pc_nx      = r_pc + 32'd4;
          w_state_nx   = S_REQ;
        end
      end
      S_DROP: begin
        if (w_redirect) w_pc_nx = w_target;
        if (imem_valid) w_state_nx = S_REQ;
        if (!w_redirect && !stall) w_bubble = 1'b1;
      end
      default: w_state_nx = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_drop_addr  <= RESET_PC;
      r_skid_pc    <= RESET_PC;
      r_skid_instr <= NOP_INSTR;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= RESET_PC;
      r_if_pc      <= RESET_PC;
      r_if_pc4     <= RESET_PC + 32'd4;
      r_if_instr   <= NOP_INSTR;
      r_if_valid   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_pc        <= w_pc_nx;
      r_drop_addr <= w_drop_nx;
      r_imem_req  <= (w_state_nx == S_REQ) || (w_state_nx == S_DROP);
      r_imem_addr <= (w_state_nx == S_DROP) ? w_drop_nx : w_pc_nx;
      if (w_skid_we) begin
        r_skid_pc    <= r_pc;
        r_skid_instr <= imem_rdata;
      end
      if (w_redirect) begin
        r_if_valid <= 1'b0;
        r_if_instr <= NOP_INSTR;
      end else if (w_load) begin
        r_if_pc    <= w_load_pc;
        r_if_pc4   <= w_load_pc + 32'd4;
        r_if_instr <= w_load_instr;
        r_if_valid <= 1'b1;
      end else if (w_bubble) begin
        r_if_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_count, r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      if (w_load && !w_redirect) r_fetch_count <= r_fetch_count + 32'd1;
      if (w_redirect)            r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign if_id_pc    = r_if_pc;
  assign if_id_pc4   = r_if_pc4;
  assign if_id_instr = r_if_instr;
  assign if_id_valid = r_if_valid;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed steps then random redirect/stall/latency traffic,
// checked against an in-order instruction-stream model and a variable-latency memory.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, branch_sel, jump, stall, imem_valid;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr, if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid;
  logic [1:0]  dbg_state;

  logic        tie0 = 1'b0;
  logic [31:0] tie32 = 32'd0;
  logic        imem_valid2;
  logic [31:0] imem_rdata2;
  logic        imem_req2;
  logic [31:0] imem_addr2, if_id_pc2, if_id_pc4_2, if_id_instr2;
  logic        if_id_valid2;
  logic [1:0]  dbg_state2;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, flush_count, fetch_count2, flush_count2;
`endif

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .branch_sel(branch_sel), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
`ifdef IF_PERF_CNT_EN
    .fetch_count(fetch_count), .flush_count(flush_count),
`endif
    .dbg_state(dbg_state)
  );

  if_fetch_stage #(.RESET_PC(RST_PC2), .NOP_INSTR(NOP)) dut2 (
    .clk(clk), .rst_n(rst_n), .branch_sel(tie0), .branch_target(tie32),
    .jump(tie0), .jump_target(tie32), .stall(tie0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .imem_valid(imem_valid2),
    .if_id_pc(if_id_pc2), .if_id_pc4(if_id_pc4_2), .if_id_instr(if_id_instr2), .if_id_valid(if_id_valid2),
`ifdef IF_PERF_CNT_EN
    .fetch_count(fetch_count2), .flush_count(flush_count2),
`endif
    .dbg_state(dbg_state2)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          mem_lat, mem_cnt, n_deliv;
  logic [31:0] exp_pc, m_fetch, m_flush;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_pc", if_id_pc, RST_PC);
    chk("rst_pc4", if_id_pc4, RST_PC + 32'd4);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst2_pc4_wrap", if_id_pc4_2, 32'h0000_0000);
  endtask

  // Memory returns its address as data after mem_lat wait cycles; garbage otherwise.
  task automatic mem_drive();
    if (imem_req && mem_cnt >= mem_lat) begin
      imem_valid = 1'b1;
      imem_rdata = imem_addr;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
    end
    imem_valid2 = imem_req2;
    imem_rdata2 = imem_addr2;
  endtask

  task automatic cycle();
    logic        pre_rst, pre_redir, pre_stall, pre_req, pre_valid, pre_ifv;
    logic [31:0] pre_tgt, pre_addr, pre_ifpc, pre_ifpc4, pre_ifinstr;
    mem_drive();
    pre_rst     = rst_n;
    pre_redir   = jump | branch_sel;
    pre_tgt     = jump ? jump_target : branch_target;
    pre_tgt[1:0] = 2'b00;
    pre_stall   = stall;
    pre_req     = imem_req;
    pre_valid   = imem_valid;
    pre_addr    = imem_addr;
    pre_ifv     = if_id_valid;
    pre_ifpc    = if_id_pc;
    pre_ifpc4   = if_id_pc4;
    pre_ifinstr = if_id_instr;
    @(posedge clk);
    #1;
    if (!rst_n || !pre_rst) begin
      mem_cnt = 0;
      exp_pc  = RST_PC;
      m_fetch = 32'd0;
      m_flush = 32'd0;
    end else begin
      if (pre_req) mem_cnt = pre_valid ? 0 : mem_cnt + 1;
      else         mem_cnt = 0;
      if (pre_req && !pre_valid) begin
        chk("proto_req_hold", 32'(imem_req), 32'd1);
        chk("proto_addr_hold", imem_addr, pre_addr);
      end
      if (pre_redir) begin
        chk("flush_valid", 32'(if_id_valid), 32'd0);
        chk("flush_instr", if_id_instr, NOP);
        exp_pc  = pre_tgt;
        m_flush = m_flush + 32'd1;
      end else if (pre_stall) begin
        chk("stall_hold_pc", if_id_pc, pre_ifpc);
        chk("stall_hold_pc4", if_id_pc4, pre_ifpc4);
        chk("stall_hold_instr", if_id_instr, pre_ifinstr);
        chk("stall_hold_valid", 32'(if_id_valid), 32'(pre_ifv));
      end else if (if_id_valid) begin
        chk("deliver_pc", if_id_pc, exp_pc);
        chk("deliver_pc4", if_id_pc4, exp_pc + 32'd4);
        chk("deliver_instr", if_id_instr, exp_pc);
        exp_pc  = exp_pc + 32'd4;
        m_fetch = m_fetch + 32'd1;
        n_deliv++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; branch_sel = 1'b0; jump = 1'b0; stall = 1'b0;
    branch_target = 32'd0; jump_target = 32'd0;
    imem_valid = 1'b0; imem_rdata = 32'd0; imem_valid2 = 1'b0; imem_rdata2 = 32'd0;
    mem_lat = 0; mem_cnt = 0; n_deliv = 0;
    exp_pc = RST_PC; m_fetch = 32'd0; m_flush = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    chk("rst2_addr", imem_addr2, RST_PC2);
    rst_n = 1'b1;

    // Boot cycle, then back-to-back fetches
    cycle();
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", imem_addr, 32'h0);
    chk("boot_ifv", 32'(if_id_valid), 32'd0);
    chk("wrap_addr0", imem_addr2, RST_PC2);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    cycle();
    chk("wrap_addr1", imem_addr2, 32'h0);
    chk("seq_pc0", if_id_pc, exp_q.pop_front());
    cycle();
    chk("seq_pc4", if_id_pc, exp_q.pop_front());

    // Stall while the response for 0x8 is valid
    stall = 1'b1;
    repeat (3) cycle();
    chk("stall_if_pc", if_id_pc, 32'h4);
    chk("stall_req_off", 32'(imem_req), 32'd0);
    stall = 1'b0;
    cycle();
    chk("unstall_pc8", if_id_pc, 32'h8);
    cycle();
    chk("unstall_pcC", if_id_pc, 32'hC);

    // Taken branch to a misaligned target
    branch_sel = 1'b1; branch_target = 32'h0000_0102;
    cycle();
    branch_sel = 1'b0;
    chk("br_ifv", 32'(if_id_valid), 32'd0);
    chk("br_instr", if_id_instr, NOP);
    chk("br_addr", imem_addr, 32'h100);
    cycle();
    chk("br_deliver", if_id_pc, 32'h100);

    // Jump during a slow-memory wait: old request must complete and be dropped
    mem_lat = 3; jump = 1'b1; jump_target = 32'h200;
    cycle();
    jump = 1'b0;
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", imem_addr, 32'h104);
    for (int i = 0; i < 12 && !(imem_req && imem_addr == 32'h200); i++) cycle();
    chk("drop_done_addr", imem_addr, 32'h200);
    chk("drop_no_load", 32'(if_id_valid), 32'd0);
    mem_lat = 0;
    cycle();
    chk("drop_deliver", if_id_pc, 32'h200);

    // Jump beats branch; redirect wins over stall
    branch_sel = 1'b1; branch_target = 32'h40; jump = 1'b1; jump_target = 32'h80;
    cycle();
    branch_sel = 1'b0; jump = 1'b0;
    chk("dual_addr", imem_addr, 32'h80);
    cycle();
    stall = 1'b1; branch_sel = 1'b1; branch_target = 32'h300;
    cycle();
    chk("rs_ifv", 32'(if_id_valid), 32'd0);
    chk("rs_instr", if_id_instr, NOP);
    stall = 1'b0; branch_sel = 1'b0;
    cycle();
    chk("rs_deliver", if_id_pc, 32'h300);
`ifdef IF_PERF_CNT_EN
    chk("fetch_count_dir", fetch_count, m_fetch);
    chk("flush_count_dir", flush_count, m_flush);
`endif

    // Asynchronous reset while an abandoned request is outstanding
    mem_lat = 3; jump = 1'b1; jump_target = 32'h500;
    cycle();
    jump = 1'b0;
    chk("rdrop_addr", imem_addr, 32'h304);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset();
    mem_cnt = 0; exp_pc = RST_PC; m_fetch = 32'd0; m_flush = 32'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_lat = 0;

    // Random traffic
    n_deliv = 0;
    for (int i = 0; i < 600; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_sel    = ($urandom_range(0, 11) == 0);
      jump          = ($urandom_range(0, 19) == 0);
      branch_target = $urandom;
      jump_target   = $urandom;
      if ($urandom_range(0, 31) == 0) mem_lat = $urandom_range(0, 3);
      cycle();
    end
    stall = 1'b0; branch_sel = 1'b0; jump = 1'b0;
    chk("rand_progress", 32'(n_deliv > 40), 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("fetch_count_rand", fetch_count, m_fetch);
    chk("flush_count_rand", flush_count, m_flush);
`endif
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
